// File: rtl/risc8_pkg.sv
// Shared types for the risc8 instruction fetch unit.
package risc8_pkg;

    typedef logic [7:0]  word;
    typedef logic [15:0] iaddr;

    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_FLUSH = 1'b1
    } e_fetch_state;

    // One prefetch buffer entry holds {instruction byte, its address}.
    localparam int FETCH_ENTRY_W = $bits(word) + $bits(iaddr);

    // Sequential instruction address; wraps from 16'hFFFF to 16'h0000.
    function automatic iaddr pc_next(input iaddr pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/risc8_fetch_fifo.sv
// Synchronous prefetch FIFO with a one-cycle flush. The head is presented
// combinationally and reads as zero while the FIFO is empty.
module risc8_fetch_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push on full still succeeds.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/risc8_fetch.sv
// Instruction fetch unit: issues byte reads ahead of decode into a small
// prefetch buffer, and drains stale in-flight reads after a redirect.
module risc8_fetch
    import risc8_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [7:0]  imem_data,
    input  logic        imem_valid,
    output logic [7:0]  instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pc_load,
    input  logic [15:0] pc_target
);

    localparam int             CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    OCC_LIMIT = (CW + 1)'(DEPTH);

    e_fetch_state               state;
    iaddr                       fetch_pc;
    iaddr                       resp_pc;
    logic [CW-1:0]              outstanding;
    logic [CW-1:0]              out_next;
    logic [CW-1:0]              fifo_count;
    logic [CW:0]                occupancy;
    logic                       fifo_empty;
    logic                       push;
    logic                       transfer;
    logic [FETCH_ENTRY_W-1:0]   head;

    // Buffered bytes plus bytes still in flight must never exceed the buffer.
    assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding};

    // rst_n is included so the request line drops the instant reset asserts.
    assign imem_rd = rst_n && (state == FS_RUN) && fetch_en && !pc_load
                     && (occupancy < OCC_LIMIT);
    assign imem_addr = fetch_pc;

    // Responses are only kept in RUN and never in a redirect cycle.
    assign push     = (state == FS_RUN) && imem_valid && !pc_load;
    assign transfer = instr_valid && instr_ready && !pc_load;

    // Every response retires one outstanding request, kept or discarded.
    assign out_next = outstanding + CW'(imem_rd) - CW'(imem_valid);

    assign instr_valid = !fifo_empty;
    assign instr       = head[FETCH_ENTRY_W-1 -: $bits(word)];
    assign instr_pc    = head[$bits(iaddr)-1:0];

    // Fetch/response address tracking, in-flight count and RUN/FLUSH control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FS_RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
        end else begin
            outstanding <= out_next;
            if (pc_load) begin
                fetch_pc <= pc_target;
                resp_pc  <= pc_target;
                state    <= (out_next != '0) ? FS_FLUSH : FS_RUN;
            end else begin
                if (imem_rd) fetch_pc <= pc_next(fetch_pc);
                if (push)    resp_pc  <= pc_next(resp_pc);
                if ((state == FS_FLUSH) && (out_next == '0)) state <= FS_RUN;
            end
        end
    end

    risc8_fetch_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (pc_load),
        .push      (push),
        .push_data ({imem_data, resp_pc}),
        .pop       (transfer),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_risc8_fetch.sv
// Randomized bench for risc8_fetch: an in-order memory with variable latency
// and a stream-level model of which byte/pc decode must see next.
module tb_risc8_fetch;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [7:0]  imem_data = 8'h00;
    logic        imem_valid = 1'b0;
    logic [7:0]  instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_target = 16'h0000;

    always #5 clk = ~clk;

    risc8_fetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_load     (pc_load),
        .pc_target   (pc_target)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          errors = 0;
    int          checks = 0;

    // Stream model: bytes buffered, requests in flight, stale requests to drop.
    int          m_out = 0;
    int          m_buf = 0;
    int          m_disc = 0;
    logic [15:0] exp_pc = RST_PC;
    logic [15:0] exp_req = RST_PC;

    logic        s_rd, s_valid;
    logic [15:0] s_addr, s_pc;
    logic [7:0]  s_instr;
    logic        p_hold = 1'b0;
    logic [7:0]  p_instr;
    logic [15:0] p_pc;

    function automatic logic [7:0] memf(input logic [15:0] a);
        return (a[7:0] + 8'h10) ^ a[15:8];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic fe, input logic rdy, input logic ld, input logic [15:0] tgt);
        logic exp_rd;
        logic disc;
        logic xfer;
        int   due;
        @(negedge clk);
        cyc++;
        fetch_en    = fe;
        instr_ready = rdy;
        pc_load     = ld;
        pc_target   = tgt;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_data  = memf(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_valid = 1'b0;
            imem_data  = 8'($urandom);
        end
        #1;
        s_rd = imem_rd; s_addr = imem_addr; s_valid = instr_valid;
        s_pc = instr_pc; s_instr = instr;

        exp_rd = fe && !ld && (m_disc == 0) && (m_buf + m_out < DEPTH);
        check_eq("imem_rd", 32'(imem_rd), 32'(exp_rd));
        if (imem_rd) check_eq("imem_addr", 32'(imem_addr), 32'(exp_req));
        check_eq("instr_valid", 32'(instr_valid), 32'(m_buf > 0));
        if (instr_valid) begin
            check_eq("instr_pc", 32'(instr_pc), 32'(exp_pc));
            check_eq("instr", 32'(instr), 32'(memf(exp_pc)));
        end
        if (p_hold) begin
            check_eq("hold_instr", 32'(instr), 32'(p_instr));
            check_eq("hold_pc", 32'(instr_pc), 32'(p_pc));
        end
        p_hold  = instr_valid && !rdy && !ld;
        p_instr = instr;
        p_pc    = instr_pc;

        xfer = (m_buf > 0) && rdy && !ld;
        disc = imem_valid && (ld || m_disc > 0);
        if (imem_valid) begin
            m_out--;
            if (m_disc > 0) m_disc--;
        end
        if (imem_rd) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: imem_addr, due: due});
            m_out++;
            exp_req++;
        end
        if (ld) begin
            m_buf   = 0;
            exp_pc  = tgt;
            exp_req = tgt;
            m_disc  = m_out;
        end else begin
            if (imem_valid && !disc) m_buf++;
            if (xfer) begin
                m_buf--;
                exp_pc++;
            end
        end
    endtask

    // Assert reset (optionally mid-cycle), check the reset outputs, then release.
    task automatic do_reset(input int skew);
        @(negedge clk);
        #(skew);
        rst_n = 1'b0;
        #1;
        check_eq("rst_imem_rd", 32'(imem_rd), 32'(0));
        check_eq("rst_instr_valid", 32'(instr_valid), 32'(0));
        imem_valid  = 1'b0;
        pc_load     = 1'b0;
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_hold_rd", 32'(imem_rd), 32'(0));
        check_eq("rst_instr", 32'(instr), 32'(0));
        check_eq("rst_instr_pc", 32'(instr_pc), 32'(0));
        check_eq("rst_addr", 32'(imem_addr), 32'(RST_PC));
        mq.delete();
        m_out = 0; m_buf = 0; m_disc = 0;
        exp_pc = RST_PC; exp_req = RST_PC;
        last_due = cyc;
        p_hold = 1'b0;
        fetch_en = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int first_rd, first_vld, n, nvalid, discards, exp_disc;
        logic found, seen_rd, seen_v;
        logic [15:0] pcs[$];

        do_reset(0);

        // Bring-up with single-cycle memory.
        lat_lo = 1; lat_hi = 1;
        first_rd = -1; first_vld = -1; n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            if (s_rd && first_rd < 0) begin
                first_rd = cyc;
                check_eq("boot_first_addr", 32'(s_addr), 32'(RST_PC));
            end
            if (s_valid && first_vld < 0) first_vld = cyc;
            if (s_valid && n < 2) begin
                check_eq("boot_pc", 32'(s_pc), 32'(RST_PC) + 32'(n));
                check_eq("boot_instr", 32'(s_instr), 32'h10 + 32'(n));
                n++;
            end
        end
        check_eq("boot_count", 32'(n), 32'(2));
        check_eq("boot_latency", 32'(first_vld - first_rd), 32'(2));

        // Decode stall: buffer must fill to exactly DEPTH and stop requesting.
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
        check_eq("stall_rd_low", 32'(s_rd), 32'(0));
        check_eq("stall_valid", 32'(s_valid), 32'(1));
        nvalid = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0);
            if (s_valid) nvalid++;
        end
        check_eq("stall_buffered", 32'(nvalid), 32'(DEPTH));

        // Redirect with reads in flight.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            if (m_out == 2) found = 1'b1;
        end
        check_eq("flush_setup", 32'(found), 32'(1));
        step(1'b1, 1'b1, 1'b1, 16'h0200);
        exp_disc = m_disc;
        discards = 0; seen_rd = 1'b0; seen_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            if (imem_valid && !seen_rd) discards++;
            if (s_rd && !seen_rd) begin
                seen_rd = 1'b1;
                check_eq("flush_first_addr", 32'(s_addr), 32'h0200);
            end
            if (s_valid && !seen_v) begin
                seen_v = 1'b1;
                check_eq("flush_first_pc", 32'(s_pc), 32'h0200);
            end
        end
        check_eq("flush_resumed", 32'({seen_rd, seen_v}), 32'(3));
        check_eq("flush_discards", 32'(discards), 32'(exp_disc));

        // Address wrap at the top of memory.
        step(1'b1, 1'b1, 1'b1, 16'hFFFE);
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            if (s_valid) pcs.push_back(s_pc);
        end
        check_eq("wrap_count", 32'(pcs.size() >= 4), 32'(1));
        if (pcs.size() >= 4) begin
            check_eq("wrap_pc0", 32'(pcs[0]), 32'hFFFE);
            check_eq("wrap_pc1", 32'(pcs[1]), 32'hFFFF);
            check_eq("wrap_pc2", 32'(pcs[2]), 32'h0000);
            check_eq("wrap_pc3", 32'(pcs[3]), 32'h0001);
        end

        // Redirect coinciding with a response and a ready decode.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mq.size() > 0 && mq[0].due <= cyc + 1 && m_buf > 0) found = 1'b1;
            else step(1'b1, 1'b1, 1'b0, 16'h0);
        end
        check_eq("coinc_setup", 32'(found), 32'(1));
        step(1'b1, 1'b1, 1'b1, 16'h0040);
        check_eq("coinc_resp_seen", 32'(imem_valid), 32'(1));
        step(1'b1, 1'b1, 1'b0, 16'h0);
        check_eq("coinc_no_valid", 32'(s_valid), 32'(0));
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 16'h0);

        // Randomized traffic: stalls, fetch gating, redirects, varying latency.
        for (int i = 0; i < 4000; i++) begin
            logic ld;
            logic [15:0] tgt;
            if (i % 500 == 0) begin
                lat_lo = 1;
                lat_hi = $urandom_range(4, 1);
            end
            ld  = ($urandom_range(29, 0) == 0);
            tgt = ($urandom_range(3, 0) == 0) ? 16'hFFFC + 16'($urandom_range(3, 0))
                                               : 16'($urandom);
            step($urandom_range(7, 0) != 0, $urandom_range(3, 0) != 0, ld, tgt);
        end

        // Asynchronous reset with a full buffer, then restart from RESET_PC.
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
        check_eq("full_valid", 32'(s_valid), 32'(1));
        check_eq("full_rd_low", 32'(s_rd), 32'(0));
        do_reset(2);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        check_eq("restart_rd", 32'(s_rd), 32'(1));
        check_eq("restart_addr", 32'(s_addr), 32'(RST_PC));
        for (int i = 0; i < 20; i++) step(1'b1, $urandom_range(1, 0) != 0, 1'b0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
